// File: rtl/tdes_pkg.sv
// Shared types, constants and the key-rotation schedule for the Triple-DES round controller.
package tdes_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int NUM_PASSES = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    KEYLOAD,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    KEY_K1 = 2'd0,
    KEY_K2 = 2'd1,
    KEY_K3 = 2'd2
  } key_sel_t;

  // C/D rotation applied before a round. A decrypt pass starts from the
  // un-rotated PC1 state, so its round 0 needs no rotation at all.
  function automatic logic [1:0] des_shift_amt(input logic [3:0] round, input logic decrypt);
    logic single_step;
    single_step = (round == 4'd0) || (round == 4'd1) || (round == 4'd8) || (round == 4'd15);
    if (decrypt && (round == 4'd0)) return 2'd0;
    return single_step ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/tdes_round_controller_if.sv
// Command and datapath-control bundle of the Triple-DES round controller.
// Optional single_mode input exists only when SINGLE_DES_EN is defined.
interface tdes_round_controller_if;

  logic       start;
  logic       decrypt_mode;
  logic       abort;
`ifdef SINGLE_DES_EN
  logic       single_mode;
`endif

  logic       busy;
  logic       done;
  logic       load_block;
  logic       key_load;
  logic [1:0] key_sel;
  logic       pass_decrypt;
  logic       round_en;
  logic [3:0] round_number;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       last_round;
  logic       out_latch;

`ifdef SINGLE_DES_EN
  modport master (
    output start, decrypt_mode, abort, single_mode,
    input  busy, done, load_block, key_load, key_sel, pass_decrypt,
           round_en, round_number, key_shift, key_dir, last_round, out_latch
  );
  modport slave (
    input  start, decrypt_mode, abort, single_mode,
    output busy, done, load_block, key_load, key_sel, pass_decrypt,
           round_en, round_number, key_shift, key_dir, last_round, out_latch
  );
`else
  modport master (
    output start, decrypt_mode, abort,
    input  busy, done, load_block, key_load, key_sel, pass_decrypt,
           round_en, round_number, key_shift, key_dir, last_round, out_latch
  );
  modport slave (
    input  start, decrypt_mode, abort,
    output busy, done, load_block, key_load, key_sel, pass_decrypt,
           round_en, round_number, key_shift, key_dir, last_round, out_latch
  );
`endif

endinterface

// File: rtl/des_round_sequencer.sv
// 4-bit DES round counter with clear/enable; saturates at the last round
// and flags it so the controlling FSM decides what follows.
module des_round_sequencer
  import tdes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] round_number,
  output logic [3:0] round_next,
  output logic       last_round
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  logic [3:0] round_q;
  logic [3:0] round_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    round_d = round_q;
    if (clear) begin
      round_d = '0;
    end else if (enable && (round_q != LAST_ROUND)) begin
      round_d = round_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_number = round_q;
  assign round_next   = round_d;
  assign last_round   = (round_q == LAST_ROUND);

endmodule

// File: rtl/tdes_round_controller.sv
// Triple-DES round sequencer: 3 passes x 16 rounds (EDE encrypt, DED decrypt), all outputs registered.
// Define SINGLE_DES_EN to add single_mode, which runs one K1 pass instead of three.
module tdes_round_controller
  import tdes_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  tdes_round_controller_if.slave   bus
);

  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] pass_q, pass_d;
  logic       mode_q, mode_d;
  logic       single_q, single_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load_block_q, load_block_d;
  logic       key_load_q, key_load_d;
  key_sel_t   key_sel_q, key_sel_d;
  logic       pass_decrypt_q, pass_decrypt_d;
  logic       round_en_q, round_en_d;
  logic [1:0] key_shift_q, key_shift_d;
  logic       key_dir_q, key_dir_d;
  logic       last_round_q, last_round_d;
  logic       out_latch_q, out_latch_d;

  logic [3:0] round_number;
  logic [3:0] round_next;
  logic       round_last;

  des_round_sequencer u_round_seq (
    .clk          (clk),
    .rst          (rst),
    .clear        (state_d != ROUND),
    .enable       (state_q == ROUND),
    .round_number (round_number),
    .round_next   (round_next),
    .last_round   (round_last)
  );

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    mode_d   = mode_q;
    single_d = single_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD;
          mode_d   = bus.decrypt_mode;
          pass_d   = '0;
`ifdef SINGLE_DES_EN
          single_d = bus.single_mode;
`else
          single_d = 1'b0;
`endif
        end
      end
      LOAD:    state_d = ROUND;
      ROUND: begin
        if (round_last) begin
          if (!single_q && (pass_q < LAST_PASS)) begin
            state_d = KEYLOAD;
            pass_d  = pass_q + 2'd1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      KEYLOAD: state_d = ROUND;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) state_d = IDLE;
    if (state_d == IDLE) pass_d = '0;
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_comb begin
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == FINISH);
    out_latch_d    = (state_d == FINISH);
    load_block_d   = (state_d == LOAD);
    key_load_d     = (state_d == LOAD) || (state_d == KEYLOAD);
    round_en_d     = (state_d == ROUND);
    pass_decrypt_d = busy_d && ((pass_d == 2'd1) ^ mode_d);
    key_dir_d      = pass_decrypt_d;
    key_sel_d      = KEY_K1;
    if (busy_d && !single_d) begin
      key_sel_d = key_sel_t'(mode_d ? (LAST_PASS - pass_d) : pass_d);
    end
    key_shift_d    = round_en_d ? des_shift_amt(round_next, pass_decrypt_d) : 2'd0;
    last_round_d   = round_en_d && (round_next == 4'(NUM_ROUNDS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pass_q         <= '0;
      mode_q         <= 1'b0;
      single_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      load_block_q   <= 1'b0;
      key_load_q     <= 1'b0;
      key_sel_q      <= KEY_K1;
      pass_decrypt_q <= 1'b0;
      round_en_q     <= 1'b0;
      key_shift_q    <= 2'd0;
      key_dir_q      <= 1'b0;
      last_round_q   <= 1'b0;
      out_latch_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pass_q         <= pass_d;
      mode_q         <= mode_d;
      single_q       <= single_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      load_block_q   <= load_block_d;
      key_load_q     <= key_load_d;
      key_sel_q      <= key_sel_d;
      pass_decrypt_q <= pass_decrypt_d;
      round_en_q     <= round_en_d;
      key_shift_q    <= key_shift_d;
      key_dir_q      <= key_dir_d;
      last_round_q   <= last_round_d;
      out_latch_q    <= out_latch_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.load_block   = load_block_q;
  assign bus.key_load     = key_load_q;
  assign bus.key_sel      = key_sel_q;
  assign bus.pass_decrypt = pass_decrypt_q;
  assign bus.round_en     = round_en_q;
  assign bus.round_number = round_number;
  assign bus.key_shift    = key_shift_q;
  assign bus.key_dir      = key_dir_q;
  assign bus.last_round   = last_round_q;
  assign bus.out_latch    = out_latch_q;

endmodule

// File: tb/tb_tdes_round_controller.sv
// Self-checking bench for tdes_round_controller: milestone table, hand-written corner sequences,
// and randomized operations compared cycle by cycle against a timeline model.
module tb_tdes_round_controller;

  logic clk;
  logic rst;

  tdes_round_controller_if bus ();

  tdes_round_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       load_block;
    logic       key_load;
    logic [1:0] key_sel;
    logic       pass_decrypt;
    logic       round_en;
    logic [3:0] round_number;
    logic [1:0] key_shift;
    logic       key_dir;
    logic       last_round;
    logic       out_latch;
  } outs_t;

  typedef struct {
    bit         dec;
    int         k;
    logic [1:0] ksel;
    logic       pdec;
    logic       kload;
    logic       ren;
    logic       done;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Encrypt-direction rotation amounts for rounds 0..15.
  int enc_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.busy         = bus.busy;
    o.done         = bus.done;
    o.load_block   = bus.load_block;
    o.key_load     = bus.key_load;
    o.key_sel      = bus.key_sel;
    o.pass_decrypt = bus.pass_decrypt;
    o.round_en     = bus.round_en;
    o.round_number = bus.round_number;
    o.key_shift    = bus.key_shift;
    o.key_dir      = bus.key_dir;
    o.last_round   = bus.last_round;
    o.out_latch    = bus.out_latch;
    return o;
  endfunction

  // Expected outputs k cycles after the start-sampling edge: cycle 1 loads, then
  // each pass is 16 round cycles plus one key-load cycle; the final slot is FINISH.
  function automatic outs_t exp_at(input int k, input bit dec, input bit sgl);
    outs_t o;
    int last, p, r, j;
    o = '0;
    r = 0;
    p = 0;
    last = sgl ? 18 : 52;
    if (k < 1 || k > last) return o;
    o.busy = 1'b1;
    if (k == 1) begin
      o.load_block = 1'b1;
      o.key_load   = 1'b1;
    end else if (k == last) begin
      o.done      = 1'b1;
      o.out_latch = 1'b1;
      p = sgl ? 0 : 2;
    end else begin
      j = k - 2;
      p = j / 17;
      r = j % 17;
      if (r == 16) begin
        o.key_load = 1'b1;
        p = p + 1;
      end else begin
        o.round_en     = 1'b1;
        o.round_number = 4'(r);
        o.last_round   = (r == 15);
      end
    end
    o.pass_decrypt = (p == 1) ^ dec;
    o.key_dir      = o.pass_decrypt;
    o.key_sel      = sgl ? 2'd0 : (dec ? 2'(2 - p) : 2'(p));
    if (o.round_en) o.key_shift = (o.pass_decrypt && r == 0) ? 2'd0 : 2'(enc_shift[r]);
    return o;
  endfunction

  task automatic set_single(input bit sgl);
`ifdef SINGLE_DES_EN
    bus.single_mode = sgl;
`else
    if (sgl) $display("note: single mode requested without SINGLE_DES_EN");
`endif
  endtask

  // Runs one operation from IDLE, comparing every cycle; optional abort or reset at cycle
  // abort_k / rst_k, start held through busy, or abort raised together with start.
  task automatic run_op(input bit dec, input bit sgl, input bit hold, input int abort_k,
                        input int rst_k, input bit abort_at_start);
    int last;
    last = sgl ? 18 : 52;
    bus.start        = 1'b1;
    bus.decrypt_mode = dec;
    bus.abort        = abort_at_start;
    set_single(sgl);
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      bus.abort        = 1'b0;
      bus.decrypt_mode = 1'($urandom);
      set_single(1'($urandom));
      check($sformatf("op dec=%0d sgl=%0d k=%0d", dec, sgl, k), 32'(sample()), 32'(exp_at(k, dec, sgl)));
      if (k == abort_k) begin
        bus.abort = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check($sformatf("after abort k=%0d", k), 32'(sample()), 32'(0));
        return;
      end
      if (k == rst_k) begin
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check($sformatf("after reset k=%0d", k), 32'(sample()), 32'(0));
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          check("idle after reset", 32'(sample()), 32'(0));
        end
        return;
      end
      if (k == last) bus.start = 1'b0;
    end
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 1,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{0, 2,  2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{0, 18, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0, 19, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{0, 35, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{0, 52, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1, 1,  2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1, 18, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1, 35, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1, 36, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1, 51, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1, 52, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst              = 1'b1;
    bus.start        = 1'b1;
    bus.decrypt_mode = 1'b0;
    bus.abort        = 1'b0;
    set_single(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset with start held", 32'(sample()), 32'(0));
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    check("idle after reset release", 32'(sample()), 32'(0));

    // Milestone table: run to cycle k, compare the listed fields, then abort back to IDLE.
    for (int i = 0; i < 12; i++) begin
      outs_t o;
      bus.start        = 1'b1;
      bus.decrypt_mode = tbl[i].dec;
      for (int k = 1; k <= tbl[i].k; k++) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      o = sample();
      if (tbl[i].kload || tbl[i].ren) begin
        check($sformatf("tbl%0d key_sel", i), 32'(o.key_sel), 32'(tbl[i].ksel));
        check($sformatf("tbl%0d pass_decrypt", i), 32'(o.pass_decrypt), 32'(tbl[i].pdec));
      end
      check($sformatf("tbl%0d key_load", i), 32'(o.key_load), 32'(tbl[i].kload));
      check($sformatf("tbl%0d round_en", i), 32'(o.round_en), 32'(tbl[i].ren));
      check($sformatf("tbl%0d done", i), 32'(o.done), 32'(tbl[i].done));
      check($sformatf("tbl%0d busy", i), 32'(o.busy), 32'(1));
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check($sformatf("tbl%0d abort busy", i), 32'(bus.busy), 32'(0));
    end

    // Encrypt pass 0: explicit rotation sequence and last_round position.
    bus.start        = 1'b1;
    bus.decrypt_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check($sformatf("enc shift r%0d", i), 32'(bus.key_shift), 32'(enc_shift[i]));
      check($sformatf("last_round r%0d", i), 32'(bus.last_round), 32'(i == 15));
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;

    // Abort in IDLE is a no-op.
    bus.abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort in idle", 32'(sample()), 32'(0));

    run_op(0, 0, 0, 0,  0,  0);
    run_op(1, 0, 0, 0,  0,  0);
    run_op(0, 0, 0, 26, 0,  0);
    run_op(1, 0, 0, 0,  0,  0);
    run_op(0, 0, 0, 0,  30, 0);
    run_op(0, 0, 1, 0,  0,  0);
    run_op(1, 0, 0, 0,  0,  1);
`ifdef SINGLE_DES_EN
    run_op(1, 1, 0, 0,  0,  0);
    run_op(0, 1, 1, 0,  0,  0);
`endif

    for (int it = 0; it < 25; it++) begin
      bit dec, sgl, hold, abort_start;
      int last, abort_k, rst_k, gap;
      dec = 1'($urandom);
`ifdef SINGLE_DES_EN
      sgl = 1'($urandom);
`else
      sgl = 1'b0;
`endif
      last        = sgl ? 18 : 52;
      hold        = ($urandom_range(0, 3) == 0);
      abort_start = ($urandom_range(0, 3) == 0);
      abort_k     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, last)) : 0;
      rst_k       = (abort_k == 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, last)) : 0;
      run_op(dec, sgl, hold, abort_k, rst_k, abort_start);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.abort = 1'($urandom);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("idle gap", 32'(sample()), 32'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
